// File: rtl/bsc_mmu_dcache_arbiter.sv
// ---------------------------------------------------------------------------
// bsc_mmu_dcache_arbiter
//
// Shares the single MMU-to-dCache request port between two page-table-walk
// requesters (0 = data-side PTW, 1 = instruction-side PTW). Round-robin
// arbitration with exactly one transaction in flight. The winning request is
// latched so the dCache adapter sees stable fields until the response. The
// selected response word goes back only to the requester that owns the
// transaction.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   flush_i               drop any pending / in-flight transaction
//   req_valid_i/ready_o   per-requester handshake (ready one-hot or zero)
//   req_addr/cmd/typ/data per-requester request fields
//   rsp_valid_o           per-requester one-cycle response pulse
//   rsp_data_o            shared response word (0 when no response)
//   dc_req_*              latched request toward the dCache adapter
//   dc_rsp_valid_i/rdata  dCache response line
//   busy_o                FSM not in IDLE
// ---------------------------------------------------------------------------
module bsc_mmu_dcache_arbiter #(
    parameter int ADDR_W       = 40,
    parameter int DATA_W       = 64,
    parameter int LINE_WORDS   = 2,
    parameter int WORD_IDX_LSB = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [1:0]                   req_valid_i,
    output logic [1:0]                   req_ready_o,
    input  logic [1:0][ADDR_W-1:0]       req_addr_i,
    input  logic [1:0][4:0]              req_cmd_i,
    input  logic [1:0][2:0]              req_typ_i,
    input  logic [1:0][DATA_W-1:0]       req_data_i,
    output logic [1:0]                   rsp_valid_o,
    output logic [DATA_W-1:0]            rsp_data_o,
    output logic                         dc_req_valid_o,
    input  logic                         dc_req_ready_i,
    output logic [ADDR_W-1:0]            dc_req_addr_o,
    output logic [4:0]                   dc_req_cmd_o,
    output logic [2:0]                   dc_req_typ_o,
    output logic [DATA_W-1:0]            dc_req_data_o,
    input  logic                         dc_rsp_valid_i,
    input  logic [LINE_WORDS*DATA_W-1:0] dc_rsp_rdata_i,
    output logic                         busy_o
);

    // Keep the index at least one bit wide so a single-word line still
    // elaborates; the word mux below falls back to word 0.
    localparam int IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic                last_q, last_d;    // last granted requester
    logic                owner_q, owner_d;  // owner of the in-flight txn
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [4:0]          cmd_q, cmd_d;
    logic [2:0]          typ_q, typ_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic                win;
    logic                take;
    logic                deliver;
    logic [1:0]          grant;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   sel_word;

    // Both valid: pick the one not granted last time. Otherwise the only
    // valid requester wins regardless of the pointer.
    always_comb begin
        if (req_valid_i[0] && req_valid_i[1]) win = ~last_q;
        else                                  win = req_valid_i[1];
    end

    // -----------------------------------------------------------------------
    // Next-state / output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant   = 2'b00;
        take    = 1'b0;
        deliver = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Ready is only ever raised toward a valid requester, so
                // raising it is the handshake.
                if (!flush_i && (|req_valid_i)) begin
                    grant[win] = 1'b1;
                    take       = 1'b1;
                    last_d     = win;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (dc_req_ready_i) begin
                    if (dc_rsp_valid_i) begin
                        // Response in the handshake cycle: complete now,
                        // swallowed if a flush coincides.
                        deliver = ~flush_i;
                        state_d = S_IDLE;
                    end else begin
                        state_d = flush_i ? S_DRAIN : S_WAIT;
                    end
                end else if (flush_i) begin
                    // Not yet accepted downstream: safe to just drop it.
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (dc_rsp_valid_i) begin
                    deliver = ~flush_i;
                    state_d = S_IDLE;
                end else if (flush_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The adapter still owes a response; eat it silently.
                if (dc_rsp_valid_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch
    always_comb begin
        owner_d = owner_q;
        addr_d  = addr_q;
        cmd_d   = cmd_q;
        typ_d   = typ_q;
        data_d  = data_q;
        if (take) begin
            owner_d = win;
            addr_d  = req_addr_i[win];
            cmd_d   = req_cmd_i[win];
            typ_d   = req_typ_i[win];
            data_d  = req_data_i[win];
        end
    end

    // Response word select uses the latched address only.
    assign idx = addr_q[WORD_IDX_LSB +: IDX_W];

    always_comb begin
        sel_word = dc_rsp_rdata_i[DATA_W-1:0];
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (idx == IDX_W'(w)) sel_word = dc_rsp_rdata_i[w*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        rsp_valid_o = 2'b00;
        rsp_data_o  = '0;
        if (deliver) begin
            rsp_valid_o[owner_q] = 1'b1;
            rsp_data_o           = sel_word;
        end
    end

    assign req_ready_o    = grant;
    assign dc_req_valid_o = (state_q == S_ISSUE);
    assign busy_o         = (state_q != S_IDLE);
    assign dc_req_addr_o  = addr_q;
    assign dc_req_cmd_o   = cmd_q;
    assign dc_req_typ_o   = typ_q;
    assign dc_req_data_o  = data_q;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // last_q resets to 1 so requester 0 wins the first contended grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            addr_q  <= '0;
            cmd_q   <= '0;
            typ_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            typ_q   <= typ_d;
            data_q  <= data_d;
        end
    end

endmodule
